// File: rtl/tsi_arb_pkg.sv
// tsi_arb_pkg: shared TSI arbiter types and constants
package tsi_arb_pkg;
  localparam int TSI_W = 32;
  localparam int TSI_HDR_WORDS = 5;
  localparam logic [TSI_W-1:0] TSI_CMD_READ = 32'd0;
  localparam logic [TSI_W-1:0] TSI_CMD_WRITE = 32'd1;
  typedef enum logic [1:0] {IDLE, HDR, WDATA, RDATA} state_t;
endpackage

// File: rtl/tsi_rr_arbiter.sv
// tsi_rr_arbiter: round-robin pick of the first active request at or after the pointer
module tsi_rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (i_req[(int'(i_ptr) + k) % NREQ]) begin
        o_any = 1'b1;
        o_idx = IW'((int'(i_ptr) + k) % NREQ);
      end
    o_gnt = o_any ? NREQ'(1) << o_idx : '0;
  end
endmodule

// File: rtl/tsi_link_arbiter.sv
// tsi_link_arbiter: message-atomic sharing of one TSI link among NREQ requesters.
// Optional read-response watchdog enabled by defining TSI_ARB_TIMEOUT_EN.
module tsi_link_arbiter
  import tsi_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int IW = $clog2(NREQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*TSI_W-1:0] req_bits,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [TSI_W-1:0]     resp_bits,
  output logic                 dev_req_valid,
  input  logic                 dev_req_ready,
  output logic [TSI_W-1:0]     dev_req_bits,
  input  logic                 dev_resp_valid,
  output logic                 dev_resp_ready,
  input  logic [TSI_W-1:0]     dev_resp_bits,
  output logic                 busy,
  output logic [IW-1:0]        grant_id,
  output logic                 error
);
  state_t            r_state;
  logic [IW-1:0]     r_g, r_rr;
  logic [NREQ-1:0]   r_gnt;
  logic [2:0]        r_hdr;
  logic [TSI_W-1:0]  r_cmd, r_len;
  logic [TSI_W:0]    r_cnt;
  logic              r_err;
  logic [NREQ-1:0]   w_gnt;
  logic [IW-1:0]     w_idx, w_rr_next;
  logic              w_any, w_fwd, w_rd, w_req_fire, w_resp_fire;
`ifdef TSI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]     r_to;
`endif
  tsi_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req(req_valid),
    .i_ptr(r_rr),
    .o_gnt(w_gnt),
    .o_idx(w_idx),
    .o_any(w_any)
  );
  assign w_fwd = r_state == HDR || r_state == WDATA;
  assign w_rd = r_state == RDATA;
  assign dev_req_valid = w_fwd && req_valid[r_g];
  assign dev_req_bits = w_fwd ? req_bits[int'(r_g)*TSI_W +: TSI_W] : '0;
  assign req_ready = (w_fwd && dev_req_ready) ? r_gnt : '0;
  assign resp_valid = (w_rd && dev_resp_valid) ? r_gnt : '0;
  assign resp_bits = w_rd ? dev_resp_bits : '0;
  assign dev_resp_ready = w_rd && resp_ready[r_g];
  assign w_req_fire = dev_req_valid && dev_req_ready;
  assign w_resp_fire = dev_resp_valid && dev_resp_ready;
  assign w_rr_next = (r_g == IW'(NREQ - 1)) ? '0 : r_g + 1'b1;
  assign busy = r_state != IDLE;
  assign grant_id = r_g;
  assign error = r_err;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_g <= '0;
      r_rr <= '0;
      r_gnt <= '0;
      r_hdr <= '0;
      r_cmd <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
`ifdef TSI_ARB_TIMEOUT_EN
      r_to <= '0;
`endif
    end else
      case (r_state)
        IDLE: if (w_any) begin
          r_g <= w_idx;
          r_gnt <= w_gnt;
          r_hdr <= '0;
          r_state <= HDR;
        end
        HDR: if (w_req_fire) begin
          r_hdr <= r_hdr + 1'b1;
          if (r_hdr == 3'd0) r_cmd <= dev_req_bits;
          if (r_hdr == 3'd3) r_len <= dev_req_bits;
          if (r_hdr == 3'(TSI_HDR_WORDS - 1)) begin
            // count is len_lo+1 in 33 bits so len_lo=all-ones does not wrap
            r_cnt <= {1'b0, r_len} + 1'b1;
            if (dev_req_bits != '0) r_err <= 1'b1;
`ifdef TSI_ARB_TIMEOUT_EN
            r_to <= '0;
`endif
            if (r_cmd == TSI_CMD_WRITE) r_state <= WDATA;
            else if (r_cmd == TSI_CMD_READ) r_state <= RDATA;
            else begin
              r_err <= 1'b1;
              r_rr <= w_rr_next;
              r_state <= IDLE;
            end
          end
        end
        WDATA: if (w_req_fire) begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == 33'd1) begin
            r_rr <= w_rr_next;
            r_state <= IDLE;
          end
        end
        RDATA: begin
          if (w_resp_fire) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == 33'd1) begin
              r_rr <= w_rr_next;
              r_state <= IDLE;
            end
          end
`ifdef TSI_ARB_TIMEOUT_EN
          r_to <= w_resp_fire ? '0 : r_to + 1'b1;
          if (!w_resp_fire && r_to == TW'(TIMEOUT_CYCLES - 1)) begin
            r_err <= 1'b1;
            r_rr <= w_rr_next;
            r_state <= IDLE;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
endmodule
